// File: rtl/hazard_trap_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_trap_ctrl
//
// Pipeline sequencing controller for the 5-stage RV32 core. It sits beside
// the opcode decoder and turns decoded hazard/trap information into stage
// register enables, stage flushes and the next-PC select. It also sequences
// external-interrupt trap entry, mret return and wfi sleep, and keeps a
// saturating count of cycles in which the PC did not advance.
//
// Ports
//   clk, rst_n            core clock (rising edge), async active-low reset
//   id_rs1, id_rs2        source register indices of the ID instruction
//   id_use_rs1/_rs2       ID instruction actually reads rs1 / rs2
//   id_is_wfi             ID instruction is wfi
//   ex_rd                 destination register of the EX instruction
//   ex_memread            EX instruction is a load
//   ex_redirect           taken branch / jal / jalr resolved in EX
//   ex_is_mret            EX instruction is mret
//   im_stall, dm_stall    instruction / data memory wait
//   irq                   external interrupt, level, asynchronous to clk
//   meie                  mstatus.MIE & mie.MEIE
//   stall_cnt_clr         synchronous clear of stall_cnt
//   pc_write .. memwb_write  stage register enables
//   ifid_flush, idex_flush   replace stage content with a NOP
//   pc_sel                00 PC+4, 01 EX target, 10 mtvec, 11 mepc
//   trap_take             one-cycle pulse: save ID PC to mepc, clear MIE
//   sleeping              high while parked in WFI
//   stall_cnt             saturating count of cycles with pc_write = 0
//
// FSM states
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_RUN  | normal issue; hazards resolved by priority each cycle
//   ST_WFI  | wfi parked in ID, front end frozen, back end keeps draining
// ---------------------------------------------------------------------------
module hazard_trap_ctrl #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_wfi,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             ex_is_mret,
  input  logic             im_stall,
  input  logic             dm_stall,
  input  logic             irq,
  input  logic             meie,
  input  logic             stall_cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       pc_sel,
  output logic             trap_take,
  output logic             sleeping,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_EX_TGT = 2'b01;
  localparam logic [1:0] PC_MTVEC  = 2'b10;
  localparam logic [1:0] PC_MEPC   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_WFI = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // irq synchronizer: irq enters bit 0, irq_s is the last stage.
  logic [SYNC_STAGES-1:0] irq_sync_q;
  logic                   irq_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sync_q <= '0;
    end else begin
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq};
    end
  end

  assign irq_s = irq_sync_q[SYNC_STAGES-1];

  logic mem_stall;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic irq_pend;

  assign mem_stall = im_stall | dm_stall;
  assign rs1_hit   = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit   = id_use_rs2 & (id_rs2 == ex_rd);
  // x0 is never a real producer, so a load to x0 never stalls.
  assign load_use  = ex_memread & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
  assign irq_pend  = irq_s & meie;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pc_sel      = PC_PLUS4;
    trap_take   = 1'b0;

    if (mem_stall) begin
      // Freeze the whole pipe; any pending redirect/trap is re-evaluated
      // once memory is done because its source is still in place.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (ex_is_mret) begin
      pc_sel     = PC_MEPC;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = ST_RUN;
    end else if (ex_redirect) begin
      pc_sel     = PC_EX_TGT;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (irq_pend) begin
            // Trap wins over load-use and wfi: the ID instruction is
            // flushed and its PC becomes mepc.
            trap_take  = 1'b1;
            pc_sel     = PC_MTVEC;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (id_is_wfi) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = ST_WFI;
          end
        end
        ST_WFI: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          // Wake on the raw synchronized line; meie only decides whether
          // the wake-up also enters the trap handler.
          if (irq_s) begin
            state_d    = ST_RUN;
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            if (meie) begin
              trap_take  = 1'b1;
              pc_sel     = PC_MTVEC;
              ifid_flush = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign sleeping = (state_q == ST_WFI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (!pc_write && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
